// File: rtl/hs_ddr_word_deserializer.sv
// ---------------------------------------------------------------------------
// hs_ddr_word_deserializer
//
// HS receive front end. serial_in is sampled on both edges of RxDDRClkHS,
// so two bits arrive per rising-edge cycle. The block hunts for the sync
// word at either bit phase and locks the word boundary. It then emits
// aligned WIDTH-bit words, each with a one-cycle valid strobe. Every output
// is registered in the rising-edge domain.
//
// Parameters
//   WIDTH  word width in bits; must be even and >= 4
//   SYNC   sync word, transmitted LSB first
//
// Ports
//   RxDDRClkHS    in   HS DDR clock; data is valid on both edges
//   RxRst_n       in   asynchronous active-low reset
//   serial_in     in   HS serial data
//   deff_en       in   capture enable (HS burst active)
//   rx_pair       out  [0] = bit at previous falling edge,
//                      [1] = bit at current rising edge
//   locked        out  word boundary found
//   sync_det      out  1-cycle pulse: sync word found
//   data_out      out  aligned word, LSB = first received bit; holds between strobes
//   data_valid    out  1-cycle pulse: new data_out
//   partial_drop  out  1-cycle pulse: burst ended with an incomplete word discarded
// ---------------------------------------------------------------------------
module hs_ddr_word_deserializer #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SYNC  = 8'hB8
) (
    input  logic             RxDDRClkHS,
    input  logic             RxRst_n,
    input  logic             serial_in,
    input  logic             deff_en,
    output logic [1:0]       rx_pair,
    output logic             locked,
    output logic             sync_det,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             partial_drop
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(HALF + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HUNT,
        ST_LOCKED
    } state_e;

    state_e           state_q;
    logic             fall_q;
    logic [WIDTH:0]   hist_q;
    logic [WIDTH:0]   hist_d;
    logic [CW-1:0]    cnt_q;
    logic             off_q;
    logic [1:0]       rx_pair_q;
    logic             locked_q;
    logic             sync_det_q;
    logic [WIDTH-1:0] data_out_q;
    logic             data_valid_q;
    logic             partial_drop_q;

    logic [1:0]       pair;
    logic             m0;
    logic             m1;
    logic [WIDTH-1:0] word;
    logic             word_done;

    // The falling-edge half of the DDR capture. Its bit is older than the
    // bit that serial_in presents at the following rising edge.
    always_ff @(negedge RxDDRClkHS or negedge RxRst_n) begin
        if (!RxRst_n) fall_q <= 1'b0;
        else          fall_q <= serial_in;
    end

    assign pair = {serial_in, fall_q};

    // hist[0] is the oldest bit. New pairs enter at the top, so the older bit
    // (fall) ends up at WIDTH-1 and the newer bit (rise) at WIDTH.
    assign hist_d = {pair, hist_q[WIDTH:2]};

    // One spare history bit lets both bit phases be checked every cycle.
    // The two windows differ only by that one bit.
    assign m0 = (hist_q[WIDTH-1:0] == SYNC);
    assign m1 = (hist_q[WIDTH:1]   == SYNC);

    assign word      = off_q ? hist_q[WIDTH:1] : hist_q[WIDTH-1:0];
    assign word_done = (cnt_q == CW'(HALF));

    always_ff @(posedge RxDDRClkHS or negedge RxRst_n) begin
        if (!RxRst_n) begin
            state_q        <= ST_IDLE;
            hist_q         <= '0;
            cnt_q          <= '0;
            off_q          <= 1'b0;
            rx_pair_q      <= '0;
            locked_q       <= 1'b0;
            sync_det_q     <= 1'b0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            partial_drop_q <= 1'b0;
        end else begin
            rx_pair_q      <= pair;
            sync_det_q     <= 1'b0;
            data_valid_q   <= 1'b0;
            partial_drop_q <= 1'b0;

            if (!deff_en) begin
                // End of burst. A word that is complete on this edge is still
                // delivered. Any other leftover bits are reported as dropped.
                if (state_q == ST_LOCKED) begin
                    if (word_done) begin
                        data_out_q   <= word;
                        data_valid_q <= 1'b1;
                    end else begin
                        partial_drop_q <= 1'b1;
                    end
                end
                state_q  <= ST_IDLE;
                locked_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                case (state_q)
                    // The first enabled edge only arms the hunt. Its pair is
                    // not shifted in.
                    ST_IDLE: begin
                        state_q <= ST_HUNT;
                    end

                    ST_HUNT: begin
                        hist_q <= hist_d;
                        if (m0 || m1) begin
                            state_q    <= ST_LOCKED;
                            locked_q   <= 1'b1;
                            off_q      <= ~m0;    // offset 0 wins a tie
                            sync_det_q <= 1'b1;
                            cnt_q      <= CW'(1);
                        end
                    end

                    // Once locked, the word stream is taken as-is. A data word
                    // that equals SYNC is ordinary payload.
                    ST_LOCKED: begin
                        hist_q <= hist_d;
                        if (word_done) begin
                            data_out_q   <= word;
                            data_valid_q <= 1'b1;
                            cnt_q        <= CW'(1);
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_pair      = rx_pair_q;
    assign locked       = locked_q;
    assign sync_det     = sync_det_q;
    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign partial_drop = partial_drop_q;

endmodule
